// File: rtl/if_id_imm_stage.sv
// IF/ID pipeline register with a RUN/HALTED state machine and immediate field extraction.
// fetch_hold freezes fetch while stalled, halted, or on the cycle a HLT is captured.
module if_id_imm_stage (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic        i_if_valid,
  input  logic [15:0] i_instr_in,
  input  logic [15:0] i_pc_plus2_in,
  output logic        o_id_valid,
  output logic [15:0] o_instr_out,
  output logic [15:0] o_pc_plus2_out,
  output logic [15:0] o_imm_raw,
  output logic [3:0]  o_imm_msb,
  output logic        o_imm_signed,
  output logic        o_fetch_hold,
  output logic        o_halted,
  output logic [15:0] o_bubble_cnt
);

  typedef enum logic {ST_RUN = 1'b0, ST_HALTED = 1'b1} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_instr;
  logic [15:0] w_instr_nxt;
  logic [15:0] r_pc;
  logic [15:0] w_pc_nxt;
  logic        r_valid;
  logic        w_valid_nxt;
  logic [15:0] r_bubble_cnt;
  logic        w_load;
  logic        w_load_hlt;

  // Priority: flush > stall > halted hold > load (reset handled in the register block).
  always_comb begin
    w_state_nxt = r_state;
    w_instr_nxt = r_instr;
    w_pc_nxt    = r_pc;
    w_valid_nxt = r_valid;
    w_load      = 1'b0;
    if (i_flush) begin
      w_state_nxt = ST_RUN;
      w_instr_nxt = 16'h0000;
      w_pc_nxt    = 16'h0000;
      w_valid_nxt = 1'b0;
    end else if (i_stall) begin
      w_load = 1'b0;
    end else if (r_state == ST_HALTED) begin
      w_load = 1'b0;
    end else begin
      w_load      = 1'b1;
      w_instr_nxt = i_instr_in;
      w_pc_nxt    = i_pc_plus2_in;
      w_valid_nxt = i_if_valid;
      if (i_if_valid && (i_instr_in[15:12] == 4'hF)) begin
        w_state_nxt = ST_HALTED;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_RUN;
      r_instr      <= 16'h0000;
      r_pc         <= 16'h0000;
      r_valid      <= 1'b0;
      r_bubble_cnt <= 16'h0000;
    end else begin
      r_state <= w_state_nxt;
      r_instr <= w_instr_nxt;
      r_pc    <= w_pc_nxt;
      r_valid <= w_valid_nxt;
      if (!r_valid && (r_bubble_cnt != 16'hFFFF)) begin
        r_bubble_cnt <= r_bubble_cnt + 16'h0001;
      end
    end
  end

  assign w_load_hlt   = w_load && i_if_valid && (i_instr_in[15:12] == 4'hF);
  assign o_fetch_hold = !i_flush && (i_stall || (r_state == ST_HALTED) || w_load_hlt);
  assign o_halted     = (r_state == ST_HALTED);
  assign o_id_valid   = r_valid;
  assign o_instr_out  = r_instr;
  assign o_pc_plus2_out = r_pc;
  assign o_bubble_cnt = r_bubble_cnt;

  // Immediate fields are presented unextended; imm_msb tells the extender where the sign bit sits.
  always_comb begin
    o_imm_raw    = 16'h0000;
    o_imm_msb    = 4'd0;
    o_imm_signed = 1'b0;
    if (r_valid) begin
      case (r_instr[15:12])
        4'h4, 4'h5, 4'h6: begin
          o_imm_raw = {12'b0, r_instr[3:0]};
          o_imm_msb = 4'd3;
        end
        4'h8, 4'h9: begin
          o_imm_raw    = {11'b0, r_instr[3:0], 1'b0};
          o_imm_msb    = 4'd4;
          o_imm_signed = 1'b1;
        end
        4'hA, 4'hB: begin
          o_imm_raw = {8'b0, r_instr[7:0]};
          o_imm_msb = 4'd7;
        end
        4'hC: begin
          o_imm_raw    = {6'b0, r_instr[8:0], 1'b0};
          o_imm_msb    = 4'd9;
          o_imm_signed = 1'b1;
        end
        default: begin
          o_imm_raw = 16'h0000;
        end
      endcase
    end
  end

endmodule

// File: doc/if_id_imm_stage.md
IF_ID_IMM_STAGE -- requirements
Module: if_id_imm_stage

Interface
REQ-001 SHALL have no parameters; all widths are fixed at 16-bit instruction/PC.
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 stall  in  1  hazard unit holds the IF/ID register.
REQ-006 flush  in  1  taken branch; discard the IF/ID contents.
REQ-007 if_valid  in  1  instr_in/pc_plus2_in are valid this cycle.
REQ-008 instr_in  in  16  fetched instruction: opcode [15:12].
REQ-009 pc_plus2_in  in  16  PC+2 of the fetched instruction.
REQ-010 id_valid  out  1  registered instruction is live.
REQ-011 instr_out  out  16  registered instruction.
REQ-012 pc_plus2_out  out  16  registered PC+2.
REQ-013 imm_raw  out  16  extracted immediate, zero-padded above imm_msb; feeds the sign extender.
REQ-014 imm_msb  out  4  bit index of the immediate MSB for sign extension.
REQ-015 imm_signed  out  1  immediate requires sign extension.
REQ-016 fetch_hold  out  1  freeze PC/fetch.
REQ-017 halted  out  1  stage is in HALTED.
REQ-018 bubble_cnt  out  16  count of cycles with id_valid=0.

Function
REQ-019 SHALL hold the registers instr_r, pc_r, valid_r, state{RUN,HALTED} and bubble_cnt; imm_raw, imm_msb and imm_signed SHALL be combinational from instr_r.
REQ-020 Update priority each cycle SHALL be rst > flush > stall > HALTED hold > load.
REQ-021 On flush, valid_r SHALL be 0, instr_r SHALL be 0x0000 and pc_r SHALL be 0x0000 next cycle; state SHALL become RUN.
REQ-022 On stall without flush, all registers SHALL hold.
REQ-023 In HALTED without flush or stall, all registers SHALL hold and if_valid SHALL be ignored.
REQ-024 In the load case, instr_r SHALL take instr_in, pc_r SHALL take pc_plus2_in and valid_r SHALL take if_valid, with latency 1 cycle.
REQ-025 RUN SHALL go to HALTED when a load captures if_valid=1 and instr_in[15:12]=4'hF (HLT).
REQ-026 HALTED SHALL leave only on flush (speculative HLT cancelled) or rst.
REQ-027 id_valid SHALL equal valid_r; halted SHALL equal (state==HALTED).
REQ-028 fetch_hold SHALL equal stall OR halted OR (load of HLT this cycle), combinational, and SHALL be deasserted during flush.
REQ-029 Immediate decode, for opcodes 4/5/6 (SLL/SRA/ROR): imm_raw = {12'b0, instr[3:0]}, msb=3, signed=0.
REQ-030 Immediate decode, for opcodes 8/9 (LW/SW): imm_raw = {11'b0, instr[3:0], 1'b0}, msb=4, signed=1.
REQ-031 Immediate decode, for opcodes A/B (LLB/LHB): imm_raw = {8'b0, instr[7:0]}, msb=7, signed=0.
REQ-032 Immediate decode, for opcode C (B): imm_raw = {6'b0, instr[8:0], 1'b0}, msb=9, signed=1.
REQ-033 Immediate decode, for all other opcodes or valid_r=0: imm_raw=0, msb=0, signed=0.
REQ-034 bubble_cnt SHALL increment each cycle valid_r=0 and SHALL saturate at 0xFFFF without wrapping.
REQ-035 flush and stall asserted in the same cycle SHALL produce flush behaviour.

Reset
REQ-036 With rst=1 at a clock edge, valid_r=0, instr_r=0x0000, pc_r=0x0000, state=RUN and bubble_cnt=0 SHALL hold next cycle, regardless of the other inputs.
REQ-037 Reset in HALTED or mid-stall SHALL return the stage to RUN with an empty register.
REQ-038 All outputs SHALL be defined from the first post-reset cycle: id_valid=0, imm_raw=0, halted=0, fetch_hold=stall.

Verification
REQ-039 Load: if_valid=1, instr_in=0x8A3F (LW), pc=0x0010 -> next cycle id_valid=1, imm_raw=0x001E, imm_msb=4, imm_signed=1, pc_plus2_out=0x0010.
REQ-040 Branch: instr_in=0xC1FF -> imm_raw=0x03FE, imm_msb=9, imm_signed=1; instr_in=0xA0C8 -> imm_raw=0x00C8, imm_msb=7, imm_signed=0.
REQ-041 Stall then flush: hold for 3 cycles with stall=1 -> outputs unchanged; then stall=1 with flush=1 -> id_valid=0, instr_out=0x0000.
REQ-042 Halt: load 0xF000 -> halted=1 and fetch_hold=1; further if_valid loads are ignored for 5 cycles; flush -> halted=0 and id_valid=0.
REQ-043 Saturation: preload bubble_cnt near the limit, or run 65540 idle cycles -> bubble_cnt stays at 0xFFFF.
REQ-044 Reset mid-HALTED with stall=1 -> next cycle state=RUN, id_valid=0, bubble_cnt=0.
